// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR generator/checker pair (x^4 + x^3 + 1, period 15).
// Pure definitions; no timing and no flow control.
package lfsr_pkg;

    localparam int                LFSR_W    = 4;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 4'b0001;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } chk_state_t;

    // The generator calls this too, so both ends always agree on the sequence.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
        return {x[2:0], x[3] ^ x[2]};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear takes effect first, then the increment, in the same cycle.
// Latency 1 cycle (registered count); no flow control.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] base;

    always_comb begin
        base  = clr ? '0 : cnt_q;
        cnt_d = base;
        if (inc && (base != '1)) begin
            cnt_d = base + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR pattern checker: hunt, verify, then flywheel-lock and count bad words.
// Latency 1 cycle (all outputs registered); no backpressure, words qualified by in_valid only.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_COUNT - 1);

    chk_state_t        state_q;
    logic [LFSR_W-1:0] expected_q;
    logic [3:0]        run_cnt_q;
    logic [3:0]        miss_cnt_q;
    logic              err_pulse_q;

    logic word_match;
    logic word_zero;
    logic err_inc;

    assign word_match = (in_data == expected_q);
    assign word_zero  = (in_data == '0);
    assign err_inc    = in_valid && (state_q == LOCKED) && !word_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            expected_q  <= LFSR_SEED;
            run_cnt_q   <= 4'd0;
            miss_cnt_q  <= 4'd0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (in_valid) begin
                unique case (state_q)
                    HUNT: begin
                        // All-zero is the LFSR lockup word and can never seed a valid sequence.
                        if (!word_zero) begin
                            expected_q <= lfsr_next(in_data);
                            run_cnt_q  <= 4'd0;
                            state_q    <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (word_match) begin
                            expected_q <= lfsr_next(in_data);
                            run_cnt_q  <= run_cnt_q + 4'd1;
                            if (run_cnt_q == LOCK_LAST) begin
                                miss_cnt_q <= 4'd0;
                                state_q    <= LOCKED;
                            end
                        end else if (!word_zero) begin
                            expected_q <= lfsr_next(in_data);
                            run_cnt_q  <= 4'd0;
                        end else begin
                            state_q <= HUNT;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: the prediction advances on its own, never from the received word.
                        expected_q <= lfsr_next(expected_q);
                        if (word_match) begin
                            miss_cnt_q <= 4'd0;
                        end else begin
                            err_pulse_q <= 1'b1;
                            miss_cnt_q  <= miss_cnt_q + 4'd1;
                            if (miss_cnt_q == LOSS_LAST) begin
                                state_q <= HUNT;
                            end
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (err_inc),
        .cnt (err_count)
    );

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;

endmodule
